// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) widths, parity positions and data extraction.
`timescale 1ns/1ps
package hamming_pkg;
  localparam int CODE_W = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  localparam int P0_POS = 1;
  localparam int P1_POS = 2;
  localparam int P2_POS = 4;
  localparam int P3_POS = 8;

  localparam logic [SYN_W-1:0] SYN_MAX_CORR = 4'd12;

  function automatic logic [DATA_W-1:0] extract_data(
    input logic [CODE_W-1:0] c
  );
    return {c[11:8], c[6:4], c[2]};
  endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome of a 12-bit Hamming codeword.
`timescale 1ns/1ps
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn
);

  // Bit k checks every code bit whose 1-based position has bit k set.
  always_comb begin
    syn = '0;
    for (int k = 0; k < SYN_W; k++) begin
      for (int i = 0; i < CODE_W; i++) begin
        if ((((i + 1) >> k) & 1) == 1) begin
          syn[k] = syn[k] ^ code[i];
        end
      end
    end
  end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage Hamming(12,8) SEC decoder with error flags.
// Define HAMMING_DEC_STATS_EN to build the saturating error counters.
`timescale 1ns/1ps
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [11:0]       code_in,
  input  logic              cnt_clr,
  output logic              valid_out,
  output logic [7:0]        data_out,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [3:0]        err_pos,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [SYN_W-1:0]  s1_syn;
  logic [SYN_W-1:0]  syn;

  hamming_syndrome u_syn (
    .code (code_in),
    .syn  (syn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else begin
      s1_valid <= valid_in;
      s1_code  <= code_in;
      s1_syn   <= syn;
    end
  end

  logic [CODE_W-1:0] flip;
  logic [CODE_W-1:0] fixed;
  logic              corr;
  logic              uncorr;

  always_comb begin
    flip   = '0;
    corr   = 1'b0;
    uncorr = 1'b0;
    unique case (1'b1)
      (s1_syn == '0): ;
      (s1_syn > SYN_MAX_CORR): uncorr = 1'b1;
      default: begin
        corr = 1'b1;
        flip = CODE_W'(1) << (s1_syn - 4'd1);
      end
    endcase
    fixed = s1_code ^ flip;
  end

  // Idle cycles present all-zero outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      err_pos    <= '0;
    end else begin
      valid_out  <= s1_valid;
      data_out   <= s1_valid ? extract_data(fixed) : '0;
      err_corr   <= s1_valid & corr;
      err_uncorr <= s1_valid & uncorr;
      err_pos    <= s1_valid ? s1_syn : '0;
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (valid_out && err_corr && corr_cnt != '1)
        corr_cnt <= corr_cnt + 1'b1;
      if (valid_out && err_uncorr && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: vector table, random
// encoder-model streams, counter saturation/clear and mid-stream reset.
`timescale 1ns/1ps
module tb_hamming_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] code_in = '0;
  logic        cnt_clr = 1'b0;

  logic        valid_a, corr_a, uncorr_a;
  logic [7:0]  data_a;
  logic [3:0]  pos_a;
  logic [15:0] ccnt_a, ucnt_a;

  logic        valid_b, corr_b, uncorr_b;
  logic [7:0]  data_b;
  logic [3:0]  pos_b;
  logic [1:0]  ccnt_b, ucnt_b;

  hamming_decoder #(.CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .code_in(code_in), .cnt_clr(cnt_clr),
    .valid_out(valid_a), .data_out(data_a),
    .err_corr(corr_a), .err_uncorr(uncorr_a),
    .err_pos(pos_a), .corr_cnt(ccnt_a), .uncorr_cnt(ucnt_a)
  );

  hamming_decoder #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .code_in(code_in), .cnt_clr(cnt_clr),
    .valid_out(valid_b), .data_out(data_b),
    .err_corr(corr_b), .err_uncorr(uncorr_b),
    .err_pos(pos_b), .corr_cnt(ccnt_b), .uncorr_cnt(ucnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  typedef struct {
    logic        valid;
    logic [11:0] code;
    logic [7:0]  data;
    logic        corr;
    logic        uncorr;
    logic [3:0]  pos;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  vec_t q[$];
  int   m_corr = 0, m_uncorr = 0;
  int   m_corr_b = 0, m_uncorr_b = 0;
  vec_t tbl[8];

  function automatic bit is_pow2(int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic vec_t mk(logic v, logic [11:0] c,
      logic [7:0] d, logic cr, logic uc, logic [3:0] p);
    vec_t r;
    r.valid = v; r.code = c; r.data = d;
    r.corr = cr; r.uncorr = uc; r.pos = p;
    return r;
  endfunction

  // Reference decode: syndrome = XOR of 1-based positions of set bits.
  function automatic vec_t model(logic v, logic [11:0] c);
    vec_t r;
    int s, idx;
    logic [11:0] f;
    r = mk(v, c, 8'h00, 1'b0, 1'b0, 4'h0);
    if (!v) return r;
    s = 0;
    for (int i = 0; i < 12; i++) if (c[i]) s = s ^ (i + 1);
    f = c;
    if (s >= 1 && s <= 12) f[s-1] = ~f[s-1];
    idx = 0;
    for (int p = 1; p <= 12; p++) begin
      if (!is_pow2(p)) begin
        r.data[idx] = f[p-1];
        idx++;
      end
    end
    r.corr = (s >= 1 && s <= 12);
    r.uncorr = (s >= 13);
    r.pos = 4'(s);
    return r;
  endfunction

  function automatic logic [11:0] encode(logic [7:0] d);
    logic [11:0] c;
    int idx, s;
    c = '0;
    idx = 0;
    for (int p = 1; p <= 12; p++) begin
      if (!is_pow2(p)) begin
        c[p-1] = d[idx];
        idx++;
      end
    end
    s = 0;
    for (int i = 0; i < 12; i++) if (c[i]) s = s ^ (i + 1);
    for (int k = 0; k < 4; k++) if (((s >> k) & 1) == 1) c[(1 << k) - 1] = 1'b1;
    return c;
  endfunction

  function automatic int exp_cnt(int m);
`ifdef HAMMING_DEC_STATS_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(vec_t e);
    check("valid_out", 32'(valid_a), 32'(e.valid));
    check("data_out", 32'(data_a), 32'(e.data));
    check("err_corr", 32'(corr_a), 32'(e.corr));
    check("err_uncorr", 32'(uncorr_a), 32'(e.uncorr));
    check("err_pos", 32'(pos_a), 32'(e.pos));
    check("data_out_b", 32'(data_b), 32'(e.data));
    if (e.valid && e.corr) begin
      m_corr++;
      if (m_corr_b < 3) m_corr_b++;
    end
    if (e.valid && e.uncorr) begin
      m_uncorr++;
      if (m_uncorr_b < 3) m_uncorr_b++;
    end
  endtask

  task automatic pipe(logic v, logic [11:0] c, vec_t e);
    valid_in = v;
    code_in = c;
    q.push_back(e);
    step();
    if (q.size() == 2) compare(q.pop_front());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) pipe(1'b0, 12'h000, model(1'b0, 12'h000));
  endtask

  task automatic check_cnts(string tag);
    check({tag, " corr_cnt"}, 32'(ccnt_a), 32'(exp_cnt(m_corr)));
    check({tag, " uncorr_cnt"}, 32'(ucnt_a), 32'(exp_cnt(m_uncorr)));
    check({tag, " corr_cnt_w2"}, 32'(ccnt_b), 32'(exp_cnt(m_corr_b)));
    check({tag, " uncorr_cnt_w2"}, 32'(ucnt_b), 32'(exp_cnt(m_uncorr_b)));
  endtask

  task automatic clear_model();
    m_corr = 0; m_uncorr = 0; m_corr_b = 0; m_uncorr_b = 0;
  endtask

  initial begin
    logic [7:0]  d;
    logic [11:0] c;
    int          b;

    tbl[0] = mk(1'b1, 12'hA27, 8'hA5, 1'b0, 1'b0, 4'd0);
    tbl[1] = mk(1'b1, 12'hA07, 8'hA5, 1'b1, 1'b0, 4'd6);
    tbl[2] = mk(1'b1, 12'hA26, 8'hA5, 1'b1, 1'b0, 4'd1);
    tbl[3] = mk(1'b1, 12'h226, 8'h25, 1'b0, 1'b1, 4'd13);
    tbl[4] = mk(1'b0, 12'hFFF, 8'h00, 1'b0, 1'b0, 4'd0);
    tbl[5] = mk(1'b1, 12'h227, 8'hA5, 1'b1, 1'b0, 4'd12);
    tbl[6] = mk(1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 4'd0);
    tbl[7] = mk(1'b1, 12'hA25, 8'hA5, 1'b1, 1'b0, 4'd2);

    #12;
    check("reset valid_out", 32'(valid_a), 0);
    check("reset data_out", 32'(data_a), 0);
    check("reset flags", 32'({corr_a, uncorr_a, pos_a}), 0);
    check_cnts("reset");

    @(negedge clk);
    rst_n = 1'b1;
    step();
    q.push_back(model(1'b0, 12'h000));

    for (int i = 0; i < 8; i++) pipe(tbl[i].valid, tbl[i].code, tbl[i]);
    idle(3);
    check_cnts("table");

    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    clear_model();
    idle(1);
    check_cnts("clear");

    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      b = int'($urandom_range(11, 0));
      c = encode(d) ^ (12'h001 << b);
      pipe(1'b1, c, mk(1'b1, c, d, 1'b1, 1'b0, 4'(b + 1)));
    end
    idle(3);
    check("stream corr model", m_corr, 256);
    check_cnts("stream");

    for (int i = 0; i < 64; i++) begin
      c = 12'($urandom);
      b = int'($urandom_range(3, 0));
      pipe(b != 0, c, model(b != 0, c));
    end
    idle(3);
    check_cnts("random");

    c = encode(8'h3C) ^ 12'h010;
    pipe(1'b1, c, mk(1'b1, c, 8'h3C, 1'b1, 1'b0, 4'd5));
    pipe(1'b0, 12'h000, model(1'b0, 12'h000));
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    clear_model();
    idle(1);
    check_cnts("clear_vs_inc");

    c = encode(8'h81) ^ 12'h004;
    pipe(1'b1, c, mk(1'b1, c, 8'h81, 1'b1, 1'b0, 4'd3));
    valid_in = 1'b1;
    code_in = encode(8'h7E) ^ 12'h800;
    step();
    check("inflight valid", 32'(valid_a), 1);
    rst_n = 1'b0;
    valid_in = 1'b0;
    code_in = 12'h000;
    #1;
    check("rst valid_out", 32'(valid_a), 0);
    check("rst data_out", 32'(data_a), 0);
    check("rst err_corr", 32'(corr_a), 0);
    q.delete();
    clear_model();
    #2;
    rst_n = 1'b1;
    q.push_back(model(1'b0, 12'h000));
    idle(3);
    check_cnts("post_rst");

    c = encode(8'hC3);
    pipe(1'b1, c, mk(1'b1, c, 8'hC3, 1'b0, 1'b0, 4'd0));
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
